// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage between program memory and the instruction decoder.
//            Owns the fetch PC, reads program memory combinationally and
//            buffers {pc, word} pairs in a small prefetch FIFO. The head entry
//            is presented to the decoder with a valid flag; control logic
//            retires it with a one-cycle ack pulse. A redirect flushes the
//            FIFO and restarts fetching at a new address. Fetching stops once
//            a HALT opcode (4'hF) has been pushed.
// Ports    : clk           - rising-edge clock
//            rst_n         - asynchronous active-low reset
//            imem_addr     - program memory address (current fetch PC)
//            imem_data     - program memory word at imem_addr
//            instr         - head instruction (0 when FIFO empty)
//            instr_pc      - fetch address of head instruction (0 when empty)
//            instr_valid   - head entry present
//            instr_ack     - one-cycle pulse retiring the head entry
//            redirect      - flush FIFO and restart fetch at redirect_addr
//            redirect_addr - new fetch PC
//            halted        - HALT fetched, fetching stopped
//            fifo_count    - number of occupied FIFO entries
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  output logic [INSTR_W-1:0]         instr,
  output logic [PC_W-1:0]            instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ack,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_addr,
  output logic                       halted,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam int         CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_W-1:0]      r_fetch_pc;
  logic [PC_W-1:0]      w_fetch_pc_nxt;

  // FIFO storage. Entries are not reset: the read side is masked while the
  // FIFO is empty, so stale contents are never visible.
  logic [PC_W-1:0]      r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0]   r_instr_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_push_halt;

  // --------------------------------------------------------------------------
  // Push / pop qualification. Redirect has top priority and suppresses both;
  // an ack on an empty FIFO is dropped. A full FIFO may still accept a push
  // in the same cycle its head is retired.
  // --------------------------------------------------------------------------
  always_comb begin
    w_empty     = (r_count == '0);
    w_full      = (r_count == CNT_W'(DEPTH));
    w_pop       = instr_ack & ~w_empty & ~redirect;
    w_push      = ~redirect & (r_state == ST_FETCH) & (~w_full | w_pop);
    w_push_halt = w_push & (imem_data[INSTR_W-1 -: 4] == HALT_OP);
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: next state. The HALT word itself is queued; only further
  // fetches stop. Leaving HALTED requires a redirect.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = ST_FETCH;
    end else if (w_push_halt) begin
      w_state_nxt = ST_HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch PC. Advances only on a push, so it rests at HALT address + 1 once
  // halted. Natural modulo 2^PC_W wrap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect) begin
      w_fetch_pc_nxt = redirect_addr;
    end else if (w_push) begin
      w_fetch_pc_nxt = r_fetch_pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap naturally at their width.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= imem_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The head is read straight from FIFO registers; nothing here
  // depends combinationally on instr_ack.
  // --------------------------------------------------------------------------
  always_comb begin
    imem_addr   = r_fetch_pc;
    instr_valid = ~w_empty;
    instr       = w_empty ? '0 : r_instr_mem[r_rd_ptr];
    instr_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    halted      = (r_state == ST_HALTED);
    fifo_count  = r_count;
  end

endmodule
`default_nettype wire
